fetcher: RTL and testbench

Per-warp program-counter sequencer for the compute unit: holds PC, active mask and fetch state for every warp slot. It picks one ready warp per cycle by round-robin and issues it to the instruction cache. It then blocks that warp until the decoder reports the instruction as decoded, returning the next PC or a stop. The fetcher sits directly upstream of the instruction cache and closes the loop from the decoder's feedback port.

---
 rtl/fetcher.sv | 217 +++++++++++++++++++++
 tb/tb_fetcher.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Per-warp PC sequencer: round-robin fetch issue to the icache, one fetch in flight per warp.
// Define FETCHER_ASSERTIONS_EN to compile in the fetcher_checker protocol properties.
`ifdef FETCHER_ASSERTIONS_EN
module fetcher_checker #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int WidWidth  = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 fe_valid_i,
    input logic                 ic_ready_i,
    input logic [PcWidth-1:0]   fe_pc_i,
    input logic [WarpWidth-1:0] fe_act_mask_i,
    input logic [WidWidth-1:0]  fe_warp_id_i,
    input logic                 dec_decoded_i,
    input logic [WidWidth-1:0]  dec_warp_id_i,
    input logic                 launch_fire_i,
    input logic [WidWidth-1:0]  launch_slot_i,
    input logic [NumWarps-1:0]  ready_vec_i,
    input logic [NumWarps-1:0]  idle_vec_i
);
    logic [NumWarps-1:0] w_waiting_vec;
    assign w_waiting_vec = ~(ready_vec_i | idle_vec_i);

    a_fe_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (fe_valid_i && !ic_ready_i) |=> (fe_valid_i && $stable(fe_pc_i)
                                         && $stable(fe_act_mask_i) && $stable(fe_warp_id_i)));
    a_dec_waiting: assert property (@(posedge clk_i) disable iff (rst_i)
        dec_decoded_i |-> w_waiting_vec[dec_warp_id_i]);
    a_launch_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        launch_fire_i |-> idle_vec_i[launch_slot_i]);
    a_grant_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        fe_valid_i |-> ready_vec_i[fe_warp_id_i]);
endmodule
`endif

module fetcher #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_valid_i,
    output logic                 launch_ready_o,
    input  logic [PcWidth-1:0]   launch_pc_i,
    input  logic [WarpWidth-1:0] launch_act_mask_i,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 dec_decoded_i,
    input  logic                 dec_stop_warp_i,
    input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
    input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
    output logic [NumWarps-1:0]  warp_active_o,
    output logic                 all_idle_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READY   = 2'd1,
        S_WAITING = 2'd2
    } slot_state_e;

    slot_state_e          r_state      [NumWarps];
    slot_state_e          w_state_next [NumWarps];
    logic [PcWidth-1:0]   r_pc         [NumWarps];
    logic [WarpWidth-1:0] r_mask       [NumWarps];
    logic [WidWidth-1:0]  r_rr;
    logic [WidWidth-1:0]  r_lock_id;
    logic                 r_lock;
    logic [WidWidth-1:0]  w_grant;
    logic [WidWidth-1:0]  w_launch_slot;
    logic                 w_valid;
    logic                 w_fire;
    logic                 w_launch_fire;
    logic [NumWarps-1:0]  w_ready_vec;
    logic [NumWarps-1:0]  w_idle_vec;
    logic [NumWarps-1:0]  w_launch_hit;
    logic [NumWarps-1:0]  w_fetch_hit;
    logic [NumWarps-1:0]  w_dec_hit;

    // Per-slot status flags and the per-slot event decode (launch, fetch, decoder feedback).
    always_comb begin
        w_ready_vec  = '0;
        w_idle_vec   = '0;
        w_launch_hit = '0;
        w_fetch_hit  = '0;
        w_dec_hit    = '0;
        for (int i = 0; i < NumWarps; i++) begin
            w_ready_vec[i]  = (r_state[i] == S_READY);
            w_idle_vec[i]   = (r_state[i] == S_IDLE);
            w_launch_hit[i] = w_launch_fire && (w_launch_slot == WidWidth'(i));
            w_fetch_hit[i]  = w_fire && (w_grant == WidWidth'(i));
            w_dec_hit[i]    = dec_decoded_i && (dec_decoded_warp_id_i == WidWidth'(i))
                              && (r_state[i] == S_WAITING);
        end
    end

    // Round-robin grant from rr; descending scan so the nearest READY slot wins. Lock overrides.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = r_rr;
        for (int k = NumWarps - 1; k >= 0; k--) begin
            idx     = int'(r_rr) + k;
            idx     = (idx >= NumWarps) ? (idx - NumWarps) : idx;
            w_grant = w_ready_vec[idx[WidWidth-1:0]] ? idx[WidWidth-1:0] : w_grant;
        end
        w_grant = r_lock ? r_lock_id : w_grant;
    end

    // Lowest-index IDLE slot receives the next launch.
    always_comb begin
        w_launch_slot = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            w_launch_slot = w_idle_vec[i] ? WidWidth'(i) : w_launch_slot;
        end
    end

    assign w_valid        = (|w_ready_vec) | r_lock;
    assign w_fire         = w_valid & ic_ready_i;
    assign w_launch_fire  = launch_valid_i & launch_ready_o;
    assign launch_ready_o = |w_idle_vec;
    assign warp_active_o  = ~w_idle_vec;
    assign all_idle_o     = &w_idle_vec;
    assign fe_valid_o     = w_valid;
    assign fe_pc_o        = w_valid ? r_pc[w_grant] : '0;
    assign fe_act_mask_o  = w_valid ? r_mask[w_grant] : '0;
    assign fe_warp_id_o   = w_valid ? w_grant : '0;

    // Slot next-state: each slot reacts only to the event aimed at its current state.
    always_comb begin
        for (int i = 0; i < NumWarps; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                S_IDLE:    w_state_next[i] = w_launch_hit[i] ? S_READY : S_IDLE;
                S_READY:   w_state_next[i] = w_fetch_hit[i] ? S_WAITING : S_READY;
                S_WAITING: begin
                    if (w_dec_hit[i]) begin
                        w_state_next[i] = dec_stop_warp_i ? S_IDLE : S_READY;
                    end else begin
                        w_state_next[i] = S_WAITING;
                    end
                end
                default:   w_state_next[i] = S_IDLE;
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWarps; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NumWarps; i++) r_state[i] <= w_state_next[i];
        end
    end

    // PC and mask storage; next PC is kept as received, wrapping is the decoder's business.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWarps; i++) begin
                r_pc[i]   <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumWarps; i++) begin
                if (w_launch_hit[i]) begin
                    r_pc[i]   <= launch_pc_i;
                    r_mask[i] <= launch_act_mask_i;
                end else if (w_dec_hit[i] && !dec_stop_warp_i) begin
                    r_pc[i]   <= dec_decoded_next_pc_i;
                end
            end
        end
    end

    // Round-robin pointer and the stall lock that freezes the fetch outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_fire) begin
            r_rr      <= (int'(w_grant) == NumWarps - 1) ? '0 : w_grant + 1'b1;
            r_lock    <= 1'b0;
        end else if (w_valid) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_grant;
        end
    end

`ifdef FETCHER_ASSERTIONS_EN
    fetcher_checker #(
        .PcWidth(PcWidth), .NumWarps(NumWarps), .WarpWidth(WarpWidth), .WidWidth(WidWidth)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fe_valid_i   (fe_valid_o),
        .ic_ready_i   (ic_ready_i),
        .fe_pc_i      (fe_pc_o),
        .fe_act_mask_i(fe_act_mask_o),
        .fe_warp_id_i (fe_warp_id_o),
        .dec_decoded_i(dec_decoded_i),
        .dec_warp_id_i(dec_decoded_warp_id_i),
        .launch_fire_i(w_launch_fire),
        .launch_slot_i(w_launch_slot),
        .ready_vec_i  (w_ready_vec),
        .idle_vec_i   (w_idle_vec)
    );
`endif
endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a per-slot behavioural model checked every cycle plus literal checks.
module tb_fetcher;
    localparam int PW = 32;
    localparam int NW = 8;
    localparam int WW = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          launch_valid_i = 1'b0;
    logic          launch_ready_o;
    logic [PW-1:0] launch_pc_i = '0;
    logic [WW-1:0] launch_act_mask_i = '0;
    logic          ic_ready_i = 1'b0;
    logic          fe_valid_o;
    logic [PW-1:0] fe_pc_o;
    logic [WW-1:0] fe_act_mask_o;
    logic [IW-1:0] fe_warp_id_o;
    logic          dec_decoded_i = 1'b0;
    logic          dec_stop_warp_i = 1'b0;
    logic [IW-1:0] dec_decoded_warp_id_i = '0;
    logic [PW-1:0] dec_decoded_next_pc_i = '0;
    logic [NW-1:0] warp_active_o;
    logic          all_idle_o;

    always #5 clk = ~clk;

    fetcher dut (
        .clk_i(clk), .rst_i(rst_i),
        .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
        .launch_pc_i(launch_pc_i), .launch_act_mask_i(launch_act_mask_i),
        .ic_ready_i(ic_ready_i), .fe_valid_o(fe_valid_o), .fe_pc_o(fe_pc_o),
        .fe_act_mask_o(fe_act_mask_o), .fe_warp_id_o(fe_warp_id_o),
        .dec_decoded_i(dec_decoded_i), .dec_stop_warp_i(dec_stop_warp_i),
        .dec_decoded_warp_id_i(dec_decoded_warp_id_i),
        .dec_decoded_next_pc_i(dec_decoded_next_pc_i),
        .warp_active_o(warp_active_o), .all_idle_o(all_idle_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: slot status 0=idle 1=ready 2=waiting, plus PC/mask, rr pointer and held grant.
    int          m_st [NW];
    logic [31:0] m_pc [NW];
    logic [31:0] m_mask [NW];
    int          m_rr;
    bit          m_lock;
    int          m_lock_id;

    function automatic int m_grant();
        if (m_lock) return m_lock_id;
        for (int k = 0; k < NW; k++) begin
            if (m_st[(m_rr + k) % NW] == 1) return (m_rr + k) % NW;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_st[i] = 0; m_pc[i] = '0; m_mask[i] = '0;
        end
        m_rr = 0; m_lock = 0; m_lock_id = 0;
    endtask

    task automatic model_step();
        int g, li, did;
        bit dh;
        g = m_grant();
        li = -1;
        for (int i = NW - 1; i >= 0; i--) if (m_st[i] == 0) li = i;
        did = int'(dec_decoded_warp_id_i);
        dh = dec_decoded_i && (m_st[did] == 2);
        if (g >= 0 && ic_ready_i) begin
            m_st[g] = 2; m_rr = (g + 1) % NW; m_lock = 0;
        end else if (g >= 0) begin
            m_lock = 1; m_lock_id = g;
        end
        if (launch_valid_i && li >= 0) begin
            m_st[li] = 1; m_pc[li] = launch_pc_i; m_mask[li] = launch_act_mask_i;
        end
        if (dh) begin
            m_st[did] = dec_stop_warp_i ? 0 : 1;
            if (!dec_stop_warp_i) m_pc[did] = dec_decoded_next_pc_i;
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next edge will see.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst_i) begin
                model_reset();
            end else begin
                int g;
                logic [NW-1:0] act;
                bit any_idle;
                g = m_grant();
                act = '0;
                any_idle = 0;
                for (int i = 0; i < NW; i++) begin
                    act[i] = (m_st[i] != 0);
                    if (m_st[i] == 0) any_idle = 1;
                end
                chk("m_fe_valid", fe_valid_o, g >= 0);
                if (g >= 0) begin
                    chk("m_fe_pc", fe_pc_o, m_pc[g]);
                    chk("m_fe_mask", fe_act_mask_o, m_mask[g]);
                    chk("m_fe_id", fe_warp_id_o, g);
                end
                chk("m_launch_ready", launch_ready_o, any_idle);
                chk("m_warp_active", warp_active_o, act);
                chk("m_all_idle", all_idle_o, act == '0);
                model_step();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        launch_valid_i = 1'b0;
        dec_decoded_i = 1'b0;
        dec_stop_warp_i = 1'b0;
    endtask

    task automatic launch(input logic [31:0] pc, input logic [31:0] mask);
        launch_valid_i = 1'b1; launch_pc_i = pc; launch_act_mask_i = mask;
        step();
    endtask

    task automatic decode(input int id, input logic [31:0] npc, input bit stop);
        dec_decoded_i = 1'b1; dec_decoded_warp_id_i = id[2:0];
        dec_decoded_next_pc_i = npc; dec_stop_warp_i = stop;
        step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fe_valid", fe_valid_o, 0);
        chk("rst_fe_pc", fe_pc_o, 0);
        chk("rst_launch_ready", launch_ready_o, 1);
        chk("rst_warp_active", warp_active_o, 0);
        chk("rst_all_idle", all_idle_o, 1);
        rst_i = 1'b0;

        // First launch, ignored feedback for a READY slot, handshake and refetch.
        launch(32'h10, 32'hFFFF_FFFF);
        chk("l1_valid", fe_valid_o, 1);
        chk("l1_pc", fe_pc_o, 32'h10);
        chk("l1_id", fe_warp_id_o, 0);
        chk("l1_active", warp_active_o, 8'h01);
        decode(0, 32'h55, 1'b0);
        chk("ign_dec_pc", fe_pc_o, 32'h10);
        ic_ready_i = 1'b1; step(); ic_ready_i = 1'b0;
        chk("wait_valid", fe_valid_o, 0);
        decode(0, 32'h11, 1'b0);
        chk("refetch_valid", fe_valid_o, 1);
        chk("refetch_pc", fe_pc_o, 32'h11);
        ic_ready_i = 1'b1; step(); ic_ready_i = 1'b0;
        decode(0, 32'h0, 1'b1);
        chk("stop_idle", all_idle_o, 1);

        // Four warps, continuous ready: grants 0,1,2,3 then 0 again after wrap.
        for (int i = 0; i < 4; i++) launch(32'h100 + i * 16, 32'h1 << i);
        ic_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_id", fe_warp_id_o, i);
            step();
        end
        chk("rr_all_wait", fe_valid_o, 0);
        decode(0, 32'h101, 1'b0);
        chk("rr_wrap_id", fe_warp_id_o, 0);
        step();

        // Warp 2 stalled by the cache while slots 0 and 1 become READY.
        ic_ready_i = 1'b0;
        decode(2, 32'h222, 1'b0);
        decode(0, 32'h200, 1'b0);
        decode(1, 32'h210, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("lock_id", fe_warp_id_o, 2);
            chk("lock_pc", fe_pc_o, 32'h222);
            step();
        end
        ic_ready_i = 1'b1; step(); ic_ready_i = 1'b0;
        chk("post_lock_id", fe_warp_id_o, 0);

        // All eight slots in flight, stop of warp 1 collides with a launch attempt.
        do_reset();
        for (int i = 0; i < 8; i++) launch(32'h300 + i, 32'hFFFF_FFFF);
        ic_ready_i = 1'b1; repeat (8) step(); ic_ready_i = 1'b0;
        chk("full_ready", launch_ready_o, 0);
        launch_valid_i = 1'b1; launch_pc_i = 32'hBAD; launch_act_mask_i = 32'h1;
        decode(1, 32'h0, 1'b1);
        chk("freed_ready", launch_ready_o, 1);
        chk("freed_active", warp_active_o, 8'hFD);
        launch(32'h777, 32'hF0F0);
        chk("relaunch_active", warp_active_o, 8'hFF);
        chk("relaunch_id", fe_warp_id_o, 1);
        chk("relaunch_pc", fe_pc_o, 32'h777);
        chk("relaunch_mask", fe_act_mask_o, 32'hF0F0);

        // Asynchronous reset with every warp waiting; later feedback has no effect.
        ic_ready_i = 1'b1; step(); ic_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", fe_valid_o, 0);
        chk("arst_pc", fe_pc_o, 0);
        chk("arst_ready", launch_ready_o, 1);
        chk("arst_active", warp_active_o, 0);
        chk("arst_idle", all_idle_o, 1);
        step();
        rst_i = 1'b0;
        decode(1, 32'h999, 1'b0);
        chk("post_rst_active", warp_active_o, 0);
        chk("post_rst_valid", fe_valid_o, 0);

        // PC wrap: next PC of zero after the top address is stored as received.
        launch(32'hFFFF_FFFF, 32'h1);
        ic_ready_i = 1'b1; step(); ic_ready_i = 1'b0;
        decode(0, 32'h0, 1'b0);
        chk("wrap_valid", fe_valid_o, 1);
        chk("wrap_pc", fe_pc_o, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
